// File: rtl/mantissa_select_pipe.sv
// mantissa_select_pipe
// Registered mantissa path select between the FP adder's mantissa adder and
// the normaliser. Chooses the wide left path or the zero-extended narrow
// right path and buffers the result behind a two-entry skid (M + S), so that
// in_ready depends only on registered state. Saturating per-path counters
// record how many accepted beats took each path.

module mantissa_select_pipe #(
    parameter int LEFT_W  = 56,
    parameter int RIGHT_W = 23,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [LEFT_W-1:0]  i_left_path,
    input  logic [RIGHT_W-1:0] i_right_path,
    input  logic [SEL_W-1:0]   i_adder_msbs,
    input  logic [1:0]         i_mode,
    input  logic               i_clear_counts,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [LEFT_W-1:0]  o_mux_out,
    output logic               o_out_sel_left,
    output logic               o_out_zero,
    output logic [CNT_W-1:0]   o_left_count,
    output logic [CNT_W-1:0]   o_right_count
);

    localparam logic [1:0] MODE_AUTO  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LAST  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // main output register
    logic [LEFT_W-1:0] r_m_data;
    logic              r_m_sel;
    logic              r_m_zero;
    logic              r_m_valid;

    // skid register, only filled while M is stalled
    logic [LEFT_W-1:0] r_s_data;
    logic              r_s_sel;
    logic              r_s_zero;
    logic              r_s_valid;

    logic              r_last_sel;
    logic [CNT_W-1:0]  r_left_count;
    logic [CNT_W-1:0]  r_right_count;

    logic              w_sel_left;
    logic [LEFT_W-1:0] w_data;
    logic              w_zero;
    logic              w_accept;
    logic              w_m_free;

    // Accepting only while S is empty guarantees there is always room for the
    // beat even if M stalls in the same cycle.
    assign o_in_ready = ~r_s_valid & ~i_rst;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_m_free   = ~r_m_valid | i_out_ready;

    // Path decision and selected data for the beat currently on the input.
    always_comb begin
        w_sel_left = r_last_sel;
        case (i_mode)
            MODE_AUTO:  w_sel_left = ~|i_adder_msbs;
            MODE_LEFT:  w_sel_left = 1'b1;
            MODE_RIGHT: w_sel_left = 1'b0;
            MODE_LAST:  w_sel_left = r_last_sel;
            default:    w_sel_left = r_last_sel;
        endcase
        w_data = w_sel_left ? i_left_path : LEFT_W'(i_right_path);
        w_zero = ~|w_data;
    end

    // M/S skid buffer: S drains into M first, otherwise new beats go to M
    // when it is free and to S when M is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_data  <= '0;
            r_m_sel   <= 1'b0;
            r_m_zero  <= 1'b0;
            r_m_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_sel   <= 1'b0;
            r_s_zero  <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (r_s_valid) begin
            if (i_out_ready) begin
                r_m_data  <= r_s_data;
                r_m_sel   <= r_s_sel;
                r_m_zero  <= r_s_zero;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end
        end else if (w_m_free) begin
            r_m_valid <= w_accept;
            if (w_accept) begin
                r_m_data <= w_data;
                r_m_sel  <= w_sel_left;
                r_m_zero <= w_zero;
            end
        end else if (w_accept) begin
            r_s_data  <= w_data;
            r_s_sel   <= w_sel_left;
            r_s_zero  <= w_zero;
            r_s_valid <= 1'b1;
        end
    end

    // Remember the last decision so mode 11 can reuse it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_sel <= 1'b1;
        end else if (w_accept) begin
            r_last_sel <= w_sel_left;
        end
    end

    // Saturating path statistics; clear takes priority over an increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_counts) begin
            r_left_count  <= '0;
            r_right_count <= '0;
        end else if (w_accept) begin
            if (w_sel_left) begin
                if (r_left_count != CNT_MAX) r_left_count <= r_left_count + 1'b1;
            end else begin
                if (r_right_count != CNT_MAX) r_right_count <= r_right_count + 1'b1;
            end
        end
    end

    assign o_out_valid    = r_m_valid;
    assign o_mux_out      = r_m_data;
    assign o_out_sel_left = r_m_sel;
    assign o_out_zero     = r_m_zero;
    assign o_left_count   = r_left_count;
    assign o_right_count  = r_right_count;

endmodule

// File: tb/tb_mantissa_select_pipe.sv
// Testbench for mantissa_select_pipe: directed sequences plus a scoreboard
// queue fed at accept time and drained at output transfer time.

module tb_mantissa_select_pipe;

    localparam int LW = 56;
    localparam int RW = 23;
    localparam int SW = 3;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct {
        logic [LW-1:0] data;
        logic          sel;
        logic          zero;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] left_path;
    logic [RW-1:0] right_path;
    logic [SW-1:0] adder_msbs;
    logic [1:0]    mode;
    logic          clear_counts;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] mux_out;
    logic          out_sel_left;
    logic          out_zero;
    logic [CW-1:0] left_count;
    logic [CW-1:0] right_count;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t         sb_q[$];
    logic [CW-1:0] m_left;
    logic [CW-1:0] m_right;
    logic          m_last;
    logic          prev_stall;
    logic [LW-1:0] prev_mux;
    logic          prev_sel;

    mantissa_select_pipe #(
        .LEFT_W (LW),
        .RIGHT_W(RW),
        .SEL_W  (SW),
        .CNT_W  (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_left_path   (left_path),
        .i_right_path  (right_path),
        .i_adder_msbs  (adder_msbs),
        .i_mode        (mode),
        .i_clear_counts(clear_counts),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_mux_out     (mux_out),
        .o_out_sel_left(out_sel_left),
        .o_out_zero    (out_zero),
        .o_left_count  (left_count),
        .o_right_count (right_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard/monitor, sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        logic  acc;
        logic  sel;
        if (rst) begin
            sb_q.delete();
            m_left     = '0;
            m_right    = '0;
            m_last     = 1'b1;
            prev_stall = 1'b0;
        end else begin
            chk("left_count", 64'(left_count), 64'(m_left));
            chk("right_count", 64'(right_count), 64'(m_right));
            if (prev_stall) begin
                chk("hold_data", 64'(mux_out), 64'(prev_mux));
                chk("hold_sel", 64'(out_sel_left), 64'(prev_sel));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_beat", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 64'(mux_out), 64'(e.data));
                    chk("sb_sel", 64'(out_sel_left), 64'(e.sel));
                    chk("sb_zero", 64'(out_zero), 64'(e.zero));
                end
            end
            acc = in_valid & in_ready;
            sel = 1'b0;
            if (acc) begin
                case (mode)
                    2'b00:   sel = (adder_msbs == '0);
                    2'b01:   sel = 1'b1;
                    2'b10:   sel = 1'b0;
                    default: sel = m_last;
                endcase
                e.sel  = sel;
                e.data = sel ? left_path : {33'd0, right_path};
                e.zero = (e.data == '0);
                sb_q.push_back(e);
                m_last = sel;
            end
            if (clear_counts) begin
                m_left  = '0;
                m_right = '0;
            end else if (acc) begin
                if (sel && m_left != CMAX) m_left = m_left + 1'b1;
                if (!sel && m_right != CMAX) m_right = m_right + 1'b1;
            end
            prev_stall = out_valid & ~out_ready;
            prev_mux   = mux_out;
            prev_sel   = out_sel_left;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns just after the
    // accepting edge with in_valid dropped.
    task automatic send(input logic [1:0] md, input logic [SW-1:0] msbs,
                        input logic [LW-1:0] lp, input logic [RW-1:0] rp);
        int  waited = 0;
        bit  done   = 0;
        mode       = md;
        adder_msbs = msbs;
        left_path  = lp;
        right_path = rp;
        in_valid   = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    chk("send_timeout", 64'(0), 64'(1));
                    done = 1;
                end
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [LW-1:0] rnd56();
        return LW'({$urandom(), $urandom()});
    endfunction

    logic [LW-1:0] a_val, b_val, c_val, x_val, z_val;

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        left_path    = '0;
        right_path   = '0;
        adder_msbs   = '0;
        mode         = 2'b00;
        clear_counts = 1'b0;
        out_ready    = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mux_out", 64'(mux_out), 64'(0));
        chk("rst_sel", 64'(out_sel_left), 64'(0));
        chk("rst_zero", 64'(out_zero), 64'(0));
        chk("rst_counts", 64'({left_count, right_count}), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));
        step();

        // auto mode, left path
        send(2'b00, 3'b000, 56'h0A_BCDE_F012_3456, 23'h12345);
        chk("auto_left_valid", 64'(out_valid), 64'(1));
        chk("auto_left_mux", 64'(mux_out), 64'h0A_BCDE_F012_3456);
        chk("auto_left_sel", 64'(out_sel_left), 64'(1));
        chk("auto_left_cnt", 64'(left_count), 64'(1));

        // auto mode, right path with zero extension
        send(2'b00, 3'b100, 56'hFF_FFFF_FFFF_FFFF, 23'h7FFFFF);
        chk("auto_right_mux", 64'(mux_out), 64'h00_0000_007F_FFFF);
        chk("auto_right_sel", 64'(out_sel_left), 64'(0));
        chk("auto_right_zero", 64'(out_zero), 64'(0));
        chk("auto_right_cnt", 64'(right_count), 64'(1));
        send(2'b00, 3'b100, 56'hFF_FFFF_FFFF_FFFF, 23'h0);
        chk("zero_mux", 64'(mux_out), 64'(0));
        chk("zero_flag", 64'(out_zero), 64'(1));
        chk("zero_right_cnt", 64'(right_count), 64'(2));
        step();

        // backpressure: A in M, B in S, C held upstream
        a_val = 56'h11_1111_1111_1111;
        b_val = 56'h22_2222_2222_2222;
        c_val = 56'h33_3333_3333_3333;
        out_ready = 1'b0;
        send(2'b00, 3'b000, a_val, 23'h1);
        send(2'b00, 3'b000, b_val, 23'h2);
        mode       = 2'b00;
        adder_msbs = 3'b000;
        left_path  = c_val;
        in_valid   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_mux", 64'(mux_out), 64'(a_val));
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_a_valid", 64'(out_valid), 64'(1));
        chk("drain_a_mux", 64'(mux_out), 64'(a_val));
        chk("drain_a_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("drain_b_valid", 64'(out_valid), 64'(1));
        chk("drain_b_mux", 64'(mux_out), 64'(b_val));
        chk("drain_b_in_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_c_valid", 64'(out_valid), 64'(1));
        chk("drain_c_mux", 64'(mux_out), 64'(c_val));
        step();

        // mode overrides and repeat-last
        send(2'b10, 3'b000, rnd56(), 23'h0ABCDE);
        chk("force_right_sel", 64'(out_sel_left), 64'(0));
        for (int i = 0; i < 3; i++) begin
            send(2'b11, 3'b000, rnd56(), 23'(i + 5));
            chk("repeat_right_sel", 64'(out_sel_left), 64'(0));
            chk("repeat_right_valid", 64'(out_valid), 64'(1));
        end
        send(2'b01, 3'b111, 56'h00_0000_0000_0077, 23'h1);
        chk("force_left_sel", 64'(out_sel_left), 64'(1));
        chk("force_left_mux", 64'(mux_out), 64'h77);
        send(2'b11, 3'b111, 56'h00_0000_0000_0088, 23'h1);
        chk("repeat_left_sel", 64'(out_sel_left), 64'(1));

        // counter saturation and clear priority
        for (int i = 0; i < 20; i++) begin
            send(2'b01, 3'($urandom_range(0, 7)), rnd56(), 23'($urandom()));
        end
        chk("left_saturated", 64'(left_count), 64'(15));
        clear_counts = 1'b1;
        send(2'b01, 3'b000, rnd56(), 23'h3);
        clear_counts = 1'b0;
        chk("clear_left", 64'(left_count), 64'(0));
        chk("clear_right", 64'(right_count), 64'(0));
        step();

        // reset with both buffers full
        x_val = 56'h44_4444_4444_4444;
        out_ready = 1'b0;
        send(2'b01, 3'b000, x_val, 23'h4);
        send(2'b10, 3'b000, x_val, 23'h5);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hi_in_ready", 64'(in_ready), 64'(0));
        step();
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_mux", 64'(mux_out), 64'(0));
        chk("midrst_counts", 64'({left_count, right_count}), 64'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        step();
        z_val = 56'h55_5555_5555_5555;
        send(2'b00, 3'b000, z_val, 23'h6);
        chk("post_rst_valid", 64'(out_valid), 64'(1));
        chk("post_rst_mux", 64'(mux_out), 64'(z_val));
        chk("post_rst_cnt", 64'(left_count), 64'(1));

        repeat (4) step();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mantissa_select_pipe.md
Name: mantissa_select_pipe

Overview:
- Registered, parametrised successor to the adder's combinational mantissa path mux.
- Each cycle it chooses between the wide left path and the zero-extended narrow right path, based on the adder's top result bits or a mode override.
- It sits between the FP adder's mantissa adder and the normaliser, and decouples them with a valid/ready interface and a 2-entry skid buffer.
- It also keeps saturating path-selection statistics for debug and coverage.

Parameters:
- LEFT_W, 56, width of left path and of mux output.
- RIGHT_W, 23, width of right path; must be <= LEFT_W.
- SEL_W, 3, number of adder MSBs inspected.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- left_path  in  LEFT_W  left (wide) mantissa candidate.
- right_path  in  RIGHT_W  right (narrow) mantissa candidate.
- adder_msbs  in  SEL_W  top bits of adder output.
- mode  in  2  00 auto, 01 force left, 10 force right, 11 repeat last decision.
- clear_counts  in  1  synchronous clear of both counters.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- mux_out  out  LEFT_W  selected mantissa.
- out_sel_left  out  1  1 = beat came from left path.
- out_zero  out  1  mux_out is all zeros.
- left_count  out  CNT_W  accepted beats that selected left.
- right_count  out  CNT_W  accepted beats that selected right.

Behaviour:
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Selection, computed at accept time:
  - auto: sel_left = ~|adder_msbs.
  - mode 01: sel_left = 1. mode 10: sel_left = 0.
  - mode 11: sel_left = last_sel, the sel_left of the most recent accepted beat.
  - last_sel resets to 1 and updates on every accept, in all modes.
- Data: sel_left → data = left_path; else data = {(LEFT_W-RIGHT_W) zeros, right_path}. out_zero = ~|data, computed before registering.
- Storage: main output register (M) plus skid register (S), each holding {data, sel_left, zero, valid}.
- in_ready = ~S.valid & ~rst. It is driven only by registered state, with no combinational path from out_ready.
- Latency: a beat accepted in cycle N is visible on the outputs in cycle N+1 when M was empty or transferring in cycle N.
- Per-cycle update:
  - M empty or transferring, S empty: accepted beat loads M; no accept → M.valid clears.
  - M stalled (valid & ~out_ready), accept: beat loads S; in_ready drops next cycle.
  - S valid and M transfers: S moves to M and S clears. Any accept in that cycle cannot happen, since in_ready = 0.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Outputs stay stable while out_valid & ~out_ready.
- Counters:
  - On accept, increment left_count or right_count according to sel_left.
  - Saturate at 2^CNT_W-1; no wrap.
  - clear_counts zeroes both; clear wins over a simultaneous increment.
- Reset, synchronous and dominant over all other inputs:
  - out_valid=0, S.valid=0, mux_out=0, out_sel_left=0, out_zero=0, counters=0, last_sel=1.
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - Reset mid-stall discards both buffered beats.
- Boundaries:
  - With RIGHT_W == LEFT_W there is no zero-extension.
  - When out_ready is held low, at most 2 beats are accepted, then in_ready=0.
  - When out_ready is held high, throughput is 1 beat/cycle with S never used.

Test Plan:
- Reset then auto mode, adder_msbs=000, left_path=56'h0A_BCDE_F012_3456, out_ready=1 → next cycle out_valid=1, mux_out=56'h0A_BCDE_F012_3456, out_sel_left=1, left_count=1.
- Auto, adder_msbs=100, right_path=23'h7FFFFF → mux_out=56'h0000_0000_7F_FFFF, out_sel_left=0, right_count=1, out_zero=0. Repeat with right_path=0 → out_zero=1.
- out_ready=0, stream beats A,B,C with in_valid held → A in M, B in S, in_ready=0, C held upstream. Raise out_ready → A, B, C emerge in order on consecutive cycles with no gaps.
- mode 10 with adder_msbs=000 → right path chosen. Then mode 11 for 3 beats → all right. Then mode 01 → left. Then mode 11 → left.
- CNT_W=4: send 20 left beats → left_count saturates at 15. Assert clear_counts in the same cycle as an accept → left_count=0.
- Assert rst with M and S both full → next cycle out_valid=0, counters=0. After release in_ready=1 and the next beat has 1-cycle latency.
